synth_voice_bank: RTL and testbench

//  Parametrised multi-voice oscillator bank and mixer; successor of the 8-voice square synthesizer.
//  Per sample_tick it advances NUM_VOICES phase accumulators and generates square/saw/triangle per voice.
//  It scales each voice by its volume and sums the voices with saturation into one signed sample.

---
 rtl/synth_voice_bank_if.sv | 24 ++
 rtl/synth_voice_bank.sv | 96 +++++++++
 tb/tb_synth_voice_bank.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/synth_voice_bank_if.sv
// synth_voice_bank_if: control/voice inputs and mixed-sample outputs of the oscillator bank
interface synth_voice_bank_if #(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_W    = 32,
    parameter int OUT_W      = 16
);
    logic                    sample_tick;
    logic [PHASE_W-1:0]      phase_incs    [NUM_VOICES];
    logic [31:0]             voice_volumes [NUM_VOICES];
    logic [1:0]              waveforms     [NUM_VOICES];
    logic [NUM_VOICES-1:0]   retrigger;
    logic signed [OUT_W-1:0] out;
    logic                    out_valid;
    logic                    busy;
    logic                    overrun;
    modport master (
        output sample_tick, phase_incs, voice_volumes, waveforms, retrigger,
        input  out, out_valid, busy, overrun
    );
    modport slave (
        input  sample_tick, phase_incs, voice_volumes, waveforms, retrigger,
        output out, out_valid, busy, overrun
    );
endinterface

// File: rtl/synth_voice_bank.sv
// synth_voice_bank: time-multiplexed square/saw/triangle oscillator bank with saturating mixer
module synth_voice_bank #(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_W    = 32,
    parameter int OUT_W      = 16,
    parameter int VOL_FRAC_W = 20
) (
    input logic clk,
    input logic reset,
    synth_voice_bank_if.slave bus
);
    localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    localparam int PW = OUT_W + 33;
    localparam int AW = PW + $clog2(NUM_VOICES) + 1;
    localparam logic signed [OUT_W-1:0] POS_A = {2'b01, {(OUT_W-2){1'b0}}};
    localparam logic signed [OUT_W-1:0] NEG_A = {2'b11, {(OUT_W-2){1'b0}}};
    localparam logic signed [AW-1:0] SMAX = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nxt;

    logic [PHASE_W-1:0]      ph [NUM_VOICES];
    logic [NUM_VOICES-1:0]   pending, clr;
    logic [VW-1:0]           v;
    logic                    last;
    logic signed [AW-1:0]    acc;
    logic [PHASE_W-1:0]      ph_new;
    logic [OUT_W-1:0]        p;
    logic [1:0]              wf;
    logic signed [OUT_W-1:0] wave;
    logic signed [PW-1:0]    prod, scaled;
    logic signed [OUT_W-1:0] out_r, sat;
    logic                    out_valid_r, overrun_r;

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.overrun   = overrun_r;

    always_ff @(posedge clk) begin
        state <= reset ? IDLE : nxt;
    end

    always_comb begin
        last = v == VW'(NUM_VOICES - 1);
        nxt  = state == IDLE ? (bus.sample_tick ? RUN : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : IDLE;
    end

    always_comb begin
        bus.busy = state != IDLE;
    end

    // Voice v's wave is derived from its freshly advanced phase, not the stored one.
    always_comb begin
        ph_new = (pending[v] ? '0 : ph[v]) + bus.phase_incs[v];
        p      = ph_new[PHASE_W-1 -: OUT_W];
        wf     = bus.waveforms[v];
        wave   = wf == 2'b00 ? (p[OUT_W-1] ? POS_A : NEG_A)
               : wf == 2'b01 ? $signed({1'b0, p[OUT_W-1:1]}) - POS_A
               : wf == 2'b10 ? $signed(p[OUT_W-1] ? ~p : p) - POS_A
               : '0;
        prod   = $signed({{33{wave[OUT_W-1]}}, wave}) * $signed({{(OUT_W+1){1'b0}}, bus.voice_volumes[v]});
        scaled = prod >>> VOL_FRAC_W;
        clr    = state == RUN ? NUM_VOICES'(1) << v : '0;
        sat    = acc > SMAX ? SMAX[OUT_W-1:0] : acc < SMIN ? SMIN[OUT_W-1:0] : acc[OUT_W-1:0];
    end

    // A retrigger arriving on the voice's own processing edge survives the clear for next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) ph[i] <= '0;
            pending     <= '0;
            v           <= '0;
            acc         <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            pending     <= (pending & ~clr) | bus.retrigger;
            out_valid_r <= state == DONE;
            if (bus.sample_tick && state != IDLE) overrun_r <= 1'b1;
            if (state == IDLE && bus.sample_tick) begin
                v   <= '0;
                acc <= '0;
            end
            if (state == RUN) begin
                ph[v] <= ph_new;
                v     <= last ? '0 : v + 1'b1;
                acc   <= acc + {{(AW-PW){scaled[PW-1]}}, scaled};
            end
            if (state == DONE) out_r <= sat;
        end
    end
endmodule

// File: tb/tb_synth_voice_bank.sv
// tb_synth_voice_bank: directed checks of the oscillator bank with hand-computed samples
module tb_synth_voice_bank;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total = 0;
    longint o;
    int   lat, nvalid, vedge;

    synth_voice_bank_if #(.NUM_VOICES(8), .PHASE_W(32), .OUT_W(16)) bus ();
    synth_voice_bank dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        bus.sample_tick = 1'b0;
        bus.retrigger   = '0;
        for (int i = 0; i < 8; i++) begin
            bus.phase_incs[i]    = '0;
            bus.voice_volumes[i] = '0;
            bus.waveforms[i]     = 2'b00;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic frame(output longint res, output int l);
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        l = 0;
        while (!bus.out_valid && l < 20) begin
            step();
            l++;
        end
        res = longint'(bus.out);
    endtask

    initial begin
        longint exp1 [4] = '{-16384, 16384, 16384, -16384};
        longint exp2 [3] = '{0, 0, 16384};
        #1;
        do_reset();
        chk("reset_out", longint'(bus.out), 0);
        chk("reset_valid", longint'(bus.out_valid), 0);
        chk("reset_busy", longint'(bus.busy), 0);
        chk("reset_overrun", longint'(bus.overrun), 0);

        bus.voice_volumes[0] = 32'd1 << 20;
        bus.phase_incs[0]    = 32'h4000_0000;
        for (int k = 0; k < 4; k++) begin
            frame(o, lat);
            chk($sformatf("t1_out%0d", k), o, exp1[k]);
            chk($sformatf("t1_lat%0d", k), longint'(lat), 9);
        end
        step();
        chk("t1_valid_pulse", longint'(bus.out_valid), 0);
        chk("t1_out_hold", longint'(bus.out), -16384);

        do_reset();
        bus.voice_volumes[0] = 32'd1 << 19;
        bus.voice_volumes[1] = 32'd1 << 19;
        bus.phase_incs[0]    = 32'h4000_0000;
        bus.phase_incs[1]    = 32'h8000_0000;
        for (int k = 0; k < 3; k++) begin
            frame(o, lat);
            chk($sformatf("t2_out%0d", k), o, exp2[k]);
        end

        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.voice_volumes[i] = 32'd1 << 20;
            bus.phase_incs[i]    = 32'h4000_0000;
        end
        frame(o, lat);
        chk("t3_saturate", o, -32768);
        chk("t3_overrun", longint'(bus.overrun), 0);

        do_reset();
        bus.voice_volumes[0] = 32'd1 << 20;
        bus.phase_incs[0]    = 32'h4000_0000;
        bus.waveforms[0]     = 2'b01;
        frame(o, lat);
        chk("t4_saw", o, -8192);
        bus.retrigger[0] = 1'b1;
        step();
        bus.retrigger[0] = 1'b0;
        bus.waveforms[0] = 2'b10;
        frame(o, lat);
        chk("t4_tri_retrig", o, 0);

        do_reset();
        bus.voice_volumes[0] = 32'd1 << 20;
        bus.phase_incs[0]    = 32'h8000_0000;
        bus.waveforms[0]     = 2'b11;
        frame(o, lat);
        chk("t6_mute", o, 0);
        bus.waveforms[0] = 2'b00;
        frame(o, lat);
        chk("t6_wrap", o, -16384);

        do_reset();
        bus.voice_volumes[0] = 32'd1 << 20;
        bus.phase_incs[0]    = 32'h4000_0000;
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        chk("t5_busy_after_tick", longint'(bus.busy), 1);
        step();
        step();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        chk("t5_overrun_set", longint'(bus.overrun), 1);
        nvalid = 0;
        vedge  = -1;
        for (int e = 4; e <= 14; e++) begin
            step();
            if (bus.out_valid) begin
                nvalid++;
                vedge = e;
            end
        end
        chk("t5_nvalid", longint'(nvalid), 1);
        chk("t5_valid_edge", longint'(vedge), 9);
        chk("t5_out", longint'(bus.out), -16384);
        chk("t5_overrun_sticky", longint'(bus.overrun), 1);
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        nvalid = 0;
        for (int e = 0; e < 12; e++) begin
            step();
            if (bus.out_valid) nvalid++;
        end
        chk("t5_abort_novalid", longint'(nvalid), 0);
        chk("t5_abort_out", longint'(bus.out), 0);
        chk("t5_abort_overrun", longint'(bus.overrun), 0);
        chk("t5_abort_busy", longint'(bus.busy), 0);
        frame(o, lat);
        chk("t5_phase_zeroed", o, -16384);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
